// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit owning the architectural HI/LO registers.
// Executes MULTU/MULT (radix-2 shift-add) and DIVU/DIV (restoring), one result bit per
// cycle. Every operation takes WIDTH+1 cycles from start to result.
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous, active-high reset
//   start  launch an operation (sampled only when idle)
//   op     00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   a, b   rs / rt operands (multiplicand/dividend, multiplier/divisor)
//   mthi   write wdata to HI (idle and no start only)
//   mtlo   write wdata to LO (idle and no start only)
//   wdata  MTHI/MTLO data
//   busy   high whenever an operation is in flight
//   done   one-cycle pulse; hi/lo already hold the new result
//   hi, lo architectural HI/LO registers
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e           state_q, state_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;          // product / quotient needs negation
  logic             rem_neg_q, rem_neg_d;  // remainder takes the dividend's sign
  logic             div0_q, div0_d;
  logic [WIDTH-1:0] a_orig_q, a_orig_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;      // multiplicand or divisor magnitude
  logic [WIDTH-1:0] acc_q, acc_d;          // upper product half or partial remainder
  logic [WIDTH-1:0] mreg_q, mreg_d;        // multiplier / lower product, or quotient
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  // Operand magnitudes; the most negative value maps to itself, read as unsigned.
  logic             sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign sign_a = op[0] & a[WIDTH-1];
  assign sign_b = op[0] & b[WIDTH-1];
  assign mag_a  = sign_a ? (-a) : a;
  assign mag_b  = sign_b ? (-b) : b;

  // Multiply step: conditional add into the upper half, carry lands in the MSB after shift.
  logic [WIDTH-1:0] add_v;
  logic [WIDTH:0]   sum;

  assign add_v = mreg_q[0] ? mcand_q : '0;
  assign sum   = {1'b0, acc_q} + {1'b0, add_v};

  // Divide step: shift {rem, quot} left, then trial-subtract at W+1 bits.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted = {acc_q, mreg_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, mcand_q};

  logic [2*WIDTH-1:0] prod, prod_neg;

  assign prod     = {acc_q, mreg_q};
  assign prod_neg = -prod;

  always_comb begin
    state_d   = state_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    div0_d    = div0_q;
    a_orig_d  = a_orig_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    mreg_d    = mreg_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          // start wins over a simultaneous MT write
          is_div_d  = op[1];
          neg_d     = sign_a ^ sign_b;
          rem_neg_d = sign_a;
          div0_d    = (b == '0);
          a_orig_d  = a;
          mcand_d   = op[1] ? mag_b : mag_a;
          mreg_d    = op[1] ? mag_a : mag_b;
          acc_d     = '0;
          cnt_d     = '0;
          state_d   = StCalc;
        end else begin
          if (mthi) hi_d = wdata;
          if (mtlo) lo_d = wdata;
        end
      end

      StCalc: begin
        cnt_d = cnt_q + CntW'(1);
        if (is_div_q) begin
          if (!diff[WIDTH]) begin
            acc_d  = diff[WIDTH-1:0];
            mreg_d = {mreg_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d  = shifted[WIDTH-1:0];
            mreg_d = {mreg_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_d  = sum[WIDTH:1];
          mreg_d = {sum[0], mreg_q[WIDTH-1:1]};
        end
        if (cnt_q == CntLast) state_d = StFix;
      end

      StFix: begin
        if (!is_div_q) begin
          {hi_d, lo_d} = neg_q ? prod_neg : prod;
        end else if (div0_q) begin
          hi_d = a_orig_q;
          lo_d = '1;
        end else begin
          lo_d = neg_q ? (-mreg_q) : mreg_q;
          hi_d = rem_neg_q ? (-acc_q) : acc_q;
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
      a_orig_q  <= '0;
      mcand_q   <= '0;
      acc_q     <= '0;
      mreg_q    <= '0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      div0_q    <= div0_d;
      a_orig_q  <= a_orig_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      mreg_q    <= mreg_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed, table-driven bench for muldiv_unit plus hand sequences for
// MT writes, busy-time blocking, reset mid-operation and back-to-back launches.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Ends at the negedge right after the launch edge (first CALC cycle).
  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts negedges from the current one until done is seen (bounded).
  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  initial begin
    int lat, bcnt, extra;
    int seen_done;

    vecs[0] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1] = '{2'b01, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[2] = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[3] = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4] = '{2'b10, 32'd100,      32'd7,        32'd2,        32'd14};
    vecs[5] = '{2'b10, 32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF};
    vecs[6] = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[7] = '{2'b00, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
    vecs[8] = '{2'b11, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[9] = '{2'b11, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);

    // Table-driven operations
    for (int i = 0; i < 10; i++) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(lat, bcnt);
      check($sformatf("v%0d_latency", i), lat, 32'd33);
      check($sformatf("v%0d_busy_cycles", i), bcnt, 32'd33);
      check($sformatf("v%0d_busy_at_done", i), {31'b0, busy}, 32'd0);
      check($sformatf("v%0d_hi", i), hi, vecs[i].exp_hi);
      check($sformatf("v%0d_lo", i), lo, vecs[i].exp_lo);
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", i), {31'b0, done}, 32'd0);
    end

    // MT writes in idle
    @(negedge clk);
    mthi = 1'b1;
    mtlo = 1'b1;
    wdata = 32'h0000ABCD;
    @(negedge clk);
    mthi = 1'b0;
    mtlo = 1'b0;
    check("mt_both_hi", hi, 32'h0000ABCD);
    check("mt_both_lo", lo, 32'h0000ABCD);

    // start with simultaneous mthi: MT write dropped, then busy-time start/mthi ignored
    @(negedge clk);
    start = 1'b1;
    op    = 2'b00;
    a     = 32'd3;
    b     = 32'd4;
    mthi  = 1'b1;
    wdata = 32'h00005555;
    @(negedge clk);
    start = 1'b0;
    mthi  = 1'b0;
    check("start_prio_hi", hi, 32'h0000ABCD);
    check("start_prio_busy", {31'b0, busy}, 32'd1);
    repeat (3) @(negedge clk);
    start = 1'b1;
    op    = 2'b10;
    a     = 32'd100;
    b     = 32'd7;
    mthi  = 1'b1;
    wdata = 32'h00001234;
    @(negedge clk);
    start = 1'b0;
    mthi  = 1'b0;
    check("busy_mthi_hi", hi, 32'h0000ABCD);
    check("busy_hold_lo", lo, 32'h0000ABCD);
    wait_done(lat, bcnt);
    check("busy_latency", lat + 4, 32'd33);
    check("busy_hi", hi, 32'd0);
    check("busy_lo", lo, 32'd12);

    // Reset during the 10th CALC cycle
    launch(2'b00, 32'hFFFFFFFF, 32'h00000003);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_done", {31'b0, done}, 32'd0);
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    seen_done = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen_done++;
    end
    check("midrst_quiet", seen_done, 32'd0);

    // Back-to-back: second start in the done cycle
    launch(2'b10, 32'd100, 32'd7);
    wait_done(lat, bcnt);
    check("b2b_first_lat", lat, 32'd33);
    check("b2b_first_lo", lo, 32'd14);
    start = 1'b1;
    op    = 2'b00;
    a     = 32'd6;
    b     = 32'd7;
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", {31'b0, busy}, 32'd1);
    wait_done(extra, bcnt);
    check("b2b_second_lat", extra, 32'd33);
    check("b2b_second_hi", hi, 32'd0);
    check("b2b_second_lo", lo, 32'd42);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
